aes_key_schedule: RTL
=====================

Name: aes_key_schedule

Overview:
- Sequential AES-128 key expansion (FIPS 197 sec 5.2). Feeds the round-key stage.
- Accepts a 128-bit cipher key. Streams round keys 0..NR one at a time over a valid/ready handshake, in the exact order the round-key XOR stage consumes them.
- Generates each next key on demand; no full key table is held (unless the optional feature is compiled in).

Parameters:
- NR, 10, number of rounds; legal range 1..10. Emits NR+1 round keys.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  load key_in and begin a schedule; sampled only in IDLE
- key_in  in  128  cipher key; key_in[127:120] = byte 0; w0 = key_in[127:96]
- busy  out  1  high in any state other than IDLE
- rk_valid  out  1  round_key/round_idx valid
- rk_ready  in  1  consumer accepts current round key
- round_key  out  128  current round key, same byte order as key_in
- round_idx  out  4  index of round_key, 0..NR
- done  out  1  one-cycle pulse after key NR is accepted

Behaviour:
- Reset (async assert, sync deassert handled externally): state=IDLE; busy=0, rk_valid=0, done=0, round_idx=0, round_key=0, internal words and rcon cleared.
- States:
  - IDLE:
    - start=1: load w0..w3 from key_in, round_idx=0, go to EMIT. rk_valid=1 on the next cycle, with round_key=key_in.
  - EMIT:
    - rk_valid=1. round_key and round_idx are held stable until rk_valid&&rk_ready.
    - On handshake with round_idx==NR: go to IDLE, done=1 for one cycle, rk_valid=0.
    - On handshake with round_idx<NR: go to SUB, rk_valid=0.
  - SUB:
    - Register t = SubWord(RotWord(w3)) XOR {rcon[round_idx+1],24'h0}. Go to XOR.
  - XOR:
    - w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'. Increment round_idx. Go to EMIT.
- Latency:
  - start to first rk_valid: 1 cycle.
  - Handshake to next rk_valid: 3 cycles (SUB, XOR, EMIT asserts).
- rcon table: 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10.
- S-box: combinational lookup, 4 instances in parallel on w3 bytes, results registered in SUB.
- start while busy: ignored; key_in is not resampled.
- rk_ready high while rk_valid=0: no effect.
- rk_ready held high continuously: full schedule completes, done asserted exactly once.
- done and start in the same cycle: the new start is accepted, since the FSM is already in IDLE when done is visible.
- reset_n asserted mid-schedule: immediate return to reset values. No done pulse. No partial key is emitted after release.

Optional Feature:
- Macro: AES_KEY_SCHED_STORE_EN.
- Defined:
  - Each key is written into an internal 11x128 store as it is generated.
  - A later start whose key_in equals the stored cipher key skips SUB/XOR. Keys come from the store with back-to-back rk_valid: a handshake every cycle when rk_ready=1.
  - A different key regenerates and overwrites the store.
  - Reset invalidates the store.
- Undefined: no store. Every schedule recomputes with 3-cycle spacing.
- Output values and ordering are identical either way. Only the spacing differs.

Test Plan:
- FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> idx0 = key, idx1 = a0fafe1788542cb123a339392a6c7605, idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6, single done pulse 1 cycle after idx10 handshake.
- Same key, rk_ready held low 5 cycles at idx3 -> round_key/round_idx stable throughout, then idx3 = 3d80477d4716fe3e1e237e446d7a883b accepted; next valid exactly 3 cycles later.
- Key all zero -> idx1 = 62636363626363636263636362636363, idx10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- start pulsed at idx5 with a different key_in -> ignored; remaining keys match the original key.
- reset_n low at idx7 for 1 cycle -> all outputs 0 immediately, busy=0, no done; new start restarts at idx0.
- With AES_KEY_SCHED_STORE_EN, same A.1 key started twice -> second run produces 11 consecutive-cycle handshakes with identical values; a different key reverts to 3-cycle spacing.

Source files
------------

// File: rtl/aes_key_schedule.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_schedule
// Purpose  : On-demand AES-128 key expansion, one round key per handshake.
//            Optional round-key store enabled by AES_KEY_SCHED_STORE_EN.
// Revision : 1.0
// ============================================================================
module aes_key_schedule #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         done
);

    localparam logic [3:0] LAST_IDX = 4'(NR);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_SUB  = 2'd2,
        S_XOR  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] t;
    logic [7:0]  rcon;
    logic [3:0]  idx;
    logic        done_q;

    logic [31:0] rot_w3;
    logic [31:0] sub_w3;
    logic [31:0] nw0, nw1, nw2, nw3;
    logic        handshake;
    logic        last_key;
    logic        replay;
    logic        replay_hit;
    logic [127:0] store_rd;

    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (a^254) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] inv;
        r = a;
        for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), a);
        inv = gf_mul(r, r);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    assign rot_w3 = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        assign sub_w3[8*i +: 8] = sbox(rot_w3[8*i +: 8]);
    end

    assign nw0 = w0 ^ t;
    assign nw1 = w1 ^ nw0;
    assign nw2 = w2 ^ nw1;
    assign nw3 = w3 ^ nw2;

    assign busy      = (state != S_IDLE);
    assign rk_valid  = (state == S_EMIT);
    assign handshake = rk_valid && rk_ready;
    assign last_key  = (idx == LAST_IDX);
    assign round_key = {w0, w1, w2, w3};
    assign round_idx = idx;
    assign done      = done_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = S_EMIT;
            S_EMIT: begin
                if (handshake) begin
                    if (last_key)    state_next = S_IDLE;
                    else if (replay) state_next = S_EMIT;
                    else             state_next = S_SUB;
                end
            end
            S_SUB:   state_next = S_XOR;
            S_XOR:   state_next = S_EMIT;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w0     <= 32'h0;
            w1     <= 32'h0;
            w2     <= 32'h0;
            w3     <= 32'h0;
            t      <= 32'h0;
            rcon   <= 8'h00;
            idx    <= 4'd0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        {w0, w1, w2, w3} <= key_in;
                        idx              <= 4'd0;
                        rcon             <= 8'h01;
                    end
                end
                S_EMIT: begin
                    if (handshake) begin
                        if (last_key) begin
                            done_q <= 1'b1;
                        end else if (replay) begin
                            {w0, w1, w2, w3} <= store_rd;
                            idx              <= idx + 4'd1;
                        end
                    end
                end
                S_SUB: t <= sub_w3 ^ {rcon, 24'h0};
                S_XOR: begin
                    w0   <= nw0;
                    w1   <= nw1;
                    w2   <= nw2;
                    w3   <= nw3;
                    idx  <= idx + 4'd1;
                    rcon <= xtime(rcon);
                end
                default: ;
            endcase
        end
    end

`ifdef AES_KEY_SCHED_STORE_EN
    logic [127:0] store [0:10];
    logic         store_valid;
    logic         replay_q;

    assign replay_hit = store_valid && (key_in == store[0]);
    assign replay     = replay_q;
    assign store_rd   = store[idx + 4'd1];

    // The store only becomes trusted once a computed schedule ran to completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            store_valid <= 1'b0;
            replay_q    <= 1'b0;
        end else begin
            if (state == S_IDLE && start) begin
                replay_q <= replay_hit;
                if (!replay_hit) store_valid <= 1'b0;
            end
            if (handshake && last_key && !replay_q) store_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && start && !replay_hit) store[0] <= key_in;
        if (state == S_XOR) store[idx + 4'd1] <= {nw0, nw1, nw2, nw3};
    end
`else
    assign replay_hit = 1'b0;
    assign replay     = replay_hit;
    assign store_rd   = round_key;
`endif

endmodule
`default_nettype wire
